solver_dispatch: RTL and testbench
==================================

# solver_dispatch

Work dispatcher for the multi-solver Mandelbrot engine. It walks the complex-plane viewport row by row in 27-bit fixed-point Q6.20 and hands one pixel per cycle to whichever escape-time solver requests work. Solvers are served round-robin. Each pixel carries its linear frame address so results land in the correct framebuffer slot. It sits between the viewport registers (min/max/dx/dy) and the solver array.

## Interface
- N_SOLVERS, 10, number of requesting solvers
- WIDTH, 27, coordinate width (signed Q6.20)
- ADDR_WIDTH, 19, pixel address width

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high; one clock; all state cleared on the rising edge where reset=1
- start  in  1  begin a frame (sampled in IDLE only)
- min_x, min_y  in  WIDTH  signed viewport origin
- max_x, max_y  in  WIDTH  signed viewport limits (inclusive)
- dx, dy  in  WIDTH  positive step per column/row
- req  in  N_SOLVERS  level request, one bit per idle solver
- grant  out  N_SOLVERS  one-hot, valid with out_valid
- out_valid  out  1  pixel issued this cycle
- out_x, out_y  out  WIDTH  pixel coordinate
- out_addr  out  ADDR_WIDTH  linear pixel index, 0-based
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse at frame end

## Operation
- States: IDLE, RUN, DONE. Reset -> IDLE.
- IDLE:
  - On start, latch all viewport inputs.
  - Set cur_x=min_x, cur_y=min_y, addr=0, rr_ptr=0.
  - Go to RUN.
  - Viewport inputs are ignored outside IDLE.
- RUN, each cycle:
  - Form eligible = req & ~grant_q, where grant_q is the previous cycle's grant.
  - If eligible is nonzero, choose the first set bit at or after rr_ptr, wrapping at N_SOLVERS-1 -> 0.
  - Register grant, out_x=cur_x, out_y=cur_y, out_addr=addr, out_valid=1.
  - Set rr_ptr = chosen index + 1, mod N_SOLVERS.
  - Advance the walk on that same edge:
    - Row end: signed cur_x+dx > max_x. Then cur_x=min_x and cur_y+=dy; otherwise cur_x+=dx.
    - addr increments by 1 on every issue.
    - Frame end: (row end and signed cur_y+dy > max_y) or addr == 2^ADDR_WIDTH-1. On frame end go to DONE.
  - If eligible is zero: out_valid=0, grant=0, no advance.
- DONE: done=1 for one cycle, then IDLE. start is ignored while in DONE.
- Arithmetic: comparisons are done at WIDTH+1 bits, sign-extended, so overflow cannot wrap past max. dx=0 or dy=0 is illegal; behaviour is undefined.
- Solver contract:
  - A solver drops req in the cycle after it sees its grant bit.
  - Masking with grant_q guarantees a solver is never granted twice in consecutive cycles.

## Timing
- Reset values: grant=0, out_valid=0, out_x=0, out_y=0, out_addr=0, busy=0, done=0, state=IDLE.
- Latency:
  - start sampled at edge t -> busy=1 after edge t.
  - First possible out_valid after edge t+1.
- Grant latency: req sampled at edge t -> grant/out_* registered at edge t, visible in cycle t+1.
- Throughput: at most 1 pixel per cycle.
- Last pixel: out_valid on the final pixel and busy=1 in the same cycle. done follows in the next cycle, with busy=0.
- Reset mid-frame: dispatch is abandoned and outputs return to reset values on the next edge. Any pixel already granted is the solver's responsibility.
- start held continuously: a new frame begins the cycle after done, because DONE returns to IDLE, which then samples start.

## Configuration
- SOLVER_DISPATCH_PAUSE_EN:
  - Defined: adds input `pause` (1 bit). In RUN with pause=1, eligible is forced to zero, so no grant and no advance; state and walk position are held. pause has no effect in IDLE/DONE.
  - Undefined: no pause port, and dispatch is never stalled except by an absence of requests.

## Test plan
- Reset then idle: reset=1 for 2 cycles, req=all ones, no start -> grant=0, out_valid=0, busy=0 indefinitely.
- Small frame:
  - Setup: min_x=0, max_x=2, dx=1, min_y=0, max_y=1, dy=1, req[0] held high, start pulse.
  - Required: 6 issues, never in consecutive cycles (grant mask), with (x,y,addr) = (0,0,0), (1,0,1), (2,0,2), (0,1,3), (1,1,4), (2,1,5).
  - Then a single done pulse, then busy=0.
- Round robin:
  - Setup: req=10'h3FF held.
  - Required: grants cycle through 0,1,2,…,9,0.
  - Then req=10'b1000000001 with rr_ptr at 5 -> grant[9] first, then grant[0].
- Viewport edge:
  - Setup: min_x=-2<<20, max_x=1<<20, dx=1638, min_y=-1<<20, max_y=1<<20, dy=2185.
  - Required: rows have 1921 pixels, and the first out_x of row 1 is -2<<20.
- Reset mid-frame: assert reset after 100 issues -> next cycle out_valid=0 and busy=0. A following start restarts at addr=0.
- Pause (macro defined): pause=1 for 5 cycles mid-frame -> no out_valid, and out_addr resumes at exactly the next address.

Source files
------------

// File: rtl/solver_dispatch_if.sv
// Solver-side bus of the Mandelbrot dispatcher: work requests in, one-hot grant
// plus the issued pixel (coordinate and linear framebuffer address) out.
interface solver_dispatch_if #(
    parameter int N_SOLVERS  = 10,
    parameter int WIDTH      = 27,
    parameter int ADDR_WIDTH = 19
);
    logic [N_SOLVERS-1:0]  req;
    logic [N_SOLVERS-1:0]  grant;
    logic                  out_valid;
    logic [WIDTH-1:0]      out_x;
    logic [WIDTH-1:0]      out_y;
    logic [ADDR_WIDTH-1:0] out_addr;

    modport master (
        input  req,
        output grant, out_valid, out_x, out_y, out_addr
    );

    modport slave (
        output req,
        input  grant, out_valid, out_x, out_y, out_addr
    );
endinterface

// File: rtl/solver_dispatch.sv
// Row-major Q6.20 viewport walker handing one pixel per cycle to round-robin solvers.
// Optional SOLVER_DISPATCH_PAUSE_EN adds a pause input that stalls dispatch in RUN.
module solver_dispatch #(
    parameter int N_SOLVERS  = 10,
    parameter int WIDTH      = 27,
    parameter int ADDR_WIDTH = 19
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
`ifdef SOLVER_DISPATCH_PAUSE_EN
    input  logic                    pause,
`endif
    input  logic signed [WIDTH-1:0] min_x,
    input  logic signed [WIDTH-1:0] min_y,
    input  logic signed [WIDTH-1:0] max_x,
    input  logic signed [WIDTH-1:0] max_y,
    input  logic signed [WIDTH-1:0] dx,
    input  logic signed [WIDTH-1:0] dy,
    solver_dispatch_if.master       sbus,
    output logic                    busy,
    output logic                    done
);
    localparam int PTR_W = (N_SOLVERS > 1) ? $clog2(N_SOLVERS) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

    state_t                  state_reg, state_next;
    logic signed [WIDTH-1:0] min_x_reg, min_x_next;
    logic signed [WIDTH-1:0] max_x_reg, max_x_next;
    logic signed [WIDTH-1:0] max_y_reg, max_y_next;
    logic signed [WIDTH-1:0] dx_reg, dx_next;
    logic signed [WIDTH-1:0] dy_reg, dy_next;
    logic signed [WIDTH-1:0] cur_x_reg, cur_x_next;
    logic signed [WIDTH-1:0] cur_y_reg, cur_y_next;
    logic [ADDR_WIDTH-1:0]   addr_reg, addr_next;
    logic [PTR_W-1:0]        rr_ptr_reg, rr_ptr_next;
    logic [N_SOLVERS-1:0]    grant_reg, grant_next;
    logic                    out_valid_reg, out_valid_next;
    logic signed [WIDTH-1:0] out_x_reg, out_x_next;
    logic signed [WIDTH-1:0] out_y_reg, out_y_next;
    logic [ADDR_WIDTH-1:0]   out_addr_reg, out_addr_next;
    logic                    done_reg, done_next;

    logic                    stall;
    logic [N_SOLVERS-1:0]    eligible;
    logic [PTR_W-1:0]        cand_idx [N_SOLVERS];
    logic [N_SOLVERS-1:0]    pick_onehot;
    logic                    pick_valid;
    logic [PTR_W-1:0]        pick_idx;
    logic [PTR_W-1:0]        pick_succ;

`ifdef SOLVER_DISPATCH_PAUSE_EN
    assign stall = pause;
`else
    assign stall = 1'b0;
`endif

    // A solver granted last cycle still shows req this cycle; mask it out.
    assign eligible = stall ? '0 : (sbus.req & ~grant_reg);

    // Candidate order: rr_ptr, rr_ptr+1, ... wrapping at N_SOLVERS-1.
    for (genvar gi = 0; gi < N_SOLVERS; gi++) begin : g_cand
        logic [PTR_W:0] sum;
        assign sum = {1'b0, rr_ptr_reg} + (PTR_W+1)'(gi);
        assign cand_idx[gi] = (sum >= (PTR_W+1)'(N_SOLVERS))
                            ? PTR_W'(sum - (PTR_W+1)'(N_SOLVERS))
                            : PTR_W'(sum);
    end

    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        // Walk from the farthest candidate back so the nearest one wins.
        for (int k = N_SOLVERS - 1; k >= 0; k--) begin
            if (eligible[cand_idx[k]]) begin
                pick_valid = 1'b1;
                pick_idx   = cand_idx[k];
            end
        end
    end

    for (genvar gi = 0; gi < N_SOLVERS; gi++) begin : g_onehot
        assign pick_onehot[gi] = pick_valid && (pick_idx == PTR_W'(gi));
    end

    assign pick_succ = (pick_idx == PTR_W'(N_SOLVERS - 1)) ? '0 : pick_idx + PTR_W'(1);

    // Walk arithmetic one bit wider so a step past max cannot wrap negative.
    logic signed [WIDTH:0] x_step, y_step, max_x_ext, max_y_ext;
    logic                  row_end, col_end, last_addr, frame_end;

    assign x_step    = {cur_x_reg[WIDTH-1], cur_x_reg} + {dx_reg[WIDTH-1], dx_reg};
    assign y_step    = {cur_y_reg[WIDTH-1], cur_y_reg} + {dy_reg[WIDTH-1], dy_reg};
    assign max_x_ext = {max_x_reg[WIDTH-1], max_x_reg};
    assign max_y_ext = {max_y_reg[WIDTH-1], max_y_reg};
    assign row_end   = x_step > max_x_ext;
    assign col_end   = y_step > max_y_ext;
    assign last_addr = (addr_reg == '1);
    assign frame_end = (row_end && col_end) || last_addr;

    always_comb begin
        state_next     = state_reg;
        min_x_next     = min_x_reg;
        max_x_next     = max_x_reg;
        max_y_next     = max_y_reg;
        dx_next        = dx_reg;
        dy_next        = dy_reg;
        cur_x_next     = cur_x_reg;
        cur_y_next     = cur_y_reg;
        addr_next      = addr_reg;
        rr_ptr_next    = rr_ptr_reg;
        grant_next     = '0;
        out_valid_next = 1'b0;
        out_x_next     = out_x_reg;
        out_y_next     = out_y_reg;
        out_addr_next  = out_addr_reg;
        done_next      = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    min_x_next  = min_x;
                    max_x_next  = max_x;
                    max_y_next  = max_y;
                    dx_next     = dx;
                    dy_next     = dy;
                    cur_x_next  = min_x;
                    cur_y_next  = min_y;
                    addr_next   = '0;
                    rr_ptr_next = '0;
                    state_next  = ST_RUN;
                end
            end
            ST_RUN: begin
                if (pick_valid) begin
                    grant_next     = pick_onehot;
                    out_valid_next = 1'b1;
                    out_x_next     = cur_x_reg;
                    out_y_next     = cur_y_reg;
                    out_addr_next  = addr_reg;
                    rr_ptr_next    = pick_succ;
                    addr_next      = addr_reg + ADDR_WIDTH'(1);
                    if (row_end) begin
                        cur_x_next = min_x_reg;
                        cur_y_next = y_step[WIDTH-1:0];
                    end else begin
                        cur_x_next = x_step[WIDTH-1:0];
                    end
                    if (frame_end) begin
                        state_next = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                done_next  = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            min_x_reg     <= '0;
            max_x_reg     <= '0;
            max_y_reg     <= '0;
            dx_reg        <= '0;
            dy_reg        <= '0;
            cur_x_reg     <= '0;
            cur_y_reg     <= '0;
            addr_reg      <= '0;
            rr_ptr_reg    <= '0;
            grant_reg     <= '0;
            out_valid_reg <= 1'b0;
            out_x_reg     <= '0;
            out_y_reg     <= '0;
            out_addr_reg  <= '0;
            done_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            min_x_reg     <= min_x_next;
            max_x_reg     <= max_x_next;
            max_y_reg     <= max_y_next;
            dx_reg        <= dx_next;
            dy_reg        <= dy_next;
            cur_x_reg     <= cur_x_next;
            cur_y_reg     <= cur_y_next;
            addr_reg      <= addr_next;
            rr_ptr_reg    <= rr_ptr_next;
            grant_reg     <= grant_next;
            out_valid_reg <= out_valid_next;
            out_x_reg     <= out_x_next;
            out_y_reg     <= out_y_next;
            out_addr_reg  <= out_addr_next;
            done_reg      <= done_next;
        end
    end

    // The last pixel is registered on the edge that enters DONE, so busy covers
    // DONE to stay high alongside it; the registered done lands the cycle after.
    assign busy           = (state_reg != ST_IDLE);
    assign done           = done_reg;
    assign sbus.grant     = grant_reg;
    assign sbus.out_valid = out_valid_reg;
    assign sbus.out_x     = out_x_reg;
    assign sbus.out_y     = out_y_reg;
    assign sbus.out_addr  = out_addr_reg;
endmodule

// File: tb/tb_solver_dispatch.sv
// Directed bench for solver_dispatch: idle after reset, small frame, round robin,
// viewport row length, mid-frame reset, and pause when SOLVER_DISPATCH_PAUSE_EN is set.
module tb_solver_dispatch;
    localparam int N  = 10;
    localparam int W  = 27;
    localparam int AW = 19;

    logic                clock;
    logic                reset;
    logic                start;
`ifdef SOLVER_DISPATCH_PAUSE_EN
    logic                pause;
`endif
    logic signed [W-1:0] min_x, min_y, max_x, max_y, dx, dy;
    logic                busy, done;

    int pass_cnt  = 0;
    int total_cnt = 0;

    solver_dispatch_if #(.N_SOLVERS(N), .WIDTH(W), .ADDR_WIDTH(AW)) sbus ();

    solver_dispatch #(.N_SOLVERS(N), .WIDTH(W), .ADDR_WIDTH(AW)) dut (
        .clock (clock),
        .reset (reset),
        .start (start),
`ifdef SOLVER_DISPATCH_PAUSE_EN
        .pause (pause),
`endif
        .min_x (min_x),
        .min_y (min_y),
        .max_x (max_x),
        .max_y (max_y),
        .dx    (dx),
        .dy    (dy),
        .sbus  (sbus),
        .busy  (busy),
        .done  (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Coordinates as they appear on the unsigned 27-bit bus, zero-extended.
    function automatic logic [31:0] fx(input int v);
        logic [W-1:0] t;
        t = v[W-1:0];
        return {5'b0, t};
    endfunction

    task automatic set_view(input int mnx, input int mxx, input int ddx,
                            input int mny, input int mxy, input int ddy);
        min_x = W'(mnx);
        max_x = W'(mxx);
        dx    = W'(ddx);
        min_y = W'(mny);
        max_y = W'(mxy);
        dy    = W'(ddy);
    endtask

    task automatic start_frame();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_busy", busy, 1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        int  n_issue;
        bit  prev_valid;
        bit  seen_done;
        bit  found;
        logic [31:0] last_x;
        logic [31:0] first_addr;

        reset = 1'b1;
        start = 1'b0;
`ifdef SOLVER_DISPATCH_PAUSE_EN
        pause = 1'b0;
`endif
        sbus.req = '1;
        set_view(0, 0, 1, 0, 0, 1);

        // Reset then idle with every solver requesting.
        tick();
        tick();
        reset = 1'b0;
        chk("rst_out_x", sbus.out_x, 0);
        chk("rst_out_y", sbus.out_y, 0);
        chk("rst_addr", sbus.out_addr, 0);
        chk("rst_done", done, 0);
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("idle_valid", sbus.out_valid, 0);
            chk("idle_grant", sbus.grant, 0);
            chk("idle_busy", busy, 0);
        end

        // Small 3x2 frame with a single solver: issues every other cycle.
        set_view(0, 2, 1, 0, 1, 1);
        sbus.req = 10'h001;
        start_frame();
        n_issue    = 0;
        prev_valid = 1'b0;
        seen_done  = 1'b0;
        for (int c = 0; c < 40 && !seen_done; c++) begin
            tick();
            if (sbus.out_valid) begin
                chk("sf_consec", {31'b0, prev_valid}, 0);
                chk("sf_grant", sbus.grant, 1);
                chk("sf_busy", busy, 1);
                if (n_issue < 6) begin
                    chk("sf_x", sbus.out_x, fx(n_issue % 3));
                    chk("sf_y", sbus.out_y, fx(n_issue / 3));
                    chk("sf_addr", sbus.out_addr, n_issue);
                end
                n_issue++;
            end
            if (done) begin
                seen_done = 1'b1;
                chk("sf_count", n_issue, 6);
                chk("sf_done_busy", busy, 0);
                chk("sf_last_before_done", {31'b0, prev_valid}, 1);
            end
            prev_valid = sbus.out_valid;
        end
        chk("sf_done_seen", {31'b0, seen_done}, 1);
        tick();
        chk("sf_done_pulse", done, 0);
        chk("sf_idle_busy", busy, 0);
        chk("sf_idle_valid", sbus.out_valid, 0);

        // Round robin across all ten solvers.
        set_view(0, 1000, 1, 0, 1000, 1);
        sbus.req = 10'h3FF;
        start_frame();
        for (int i = 0; i < 11; i++) begin
            tick();
            chk("rr_valid", sbus.out_valid, 1);
            chk("rr_grant", sbus.grant, 1 << (i % 10));
        end
        for (int i = 1; i < 5; i++) begin
            tick();
            chk("rr_grant_b", sbus.grant, 1 << i);
        end
        // rr_ptr now sits at 5: only solvers 9 and 0 request.
        sbus.req = 10'b1000000001;
        tick();
        chk("rr_wrap9", sbus.grant, 10'h200);
        tick();
        chk("rr_wrap0", sbus.grant, 10'h001);
        n_issue = 17;
        sbus.req = 10'h3FF;
        while (n_issue < 100) begin
            tick();
            n_issue++;
        end
        chk("rr_addr100", sbus.out_addr, 99);

        // Reset mid-frame, then restart from address zero.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mrst_valid", sbus.out_valid, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_grant", sbus.grant, 0);
        set_view(7, 1000, 1, 3, 1000, 1);
        start_frame();
        tick();
        chk("restart_valid", sbus.out_valid, 1);
        chk("restart_addr", sbus.out_addr, 0);
        chk("restart_x", sbus.out_x, fx(7));
        chk("restart_y", sbus.out_y, fx(3));
        do_reset();

        // Real viewport: 1921 pixels per row, row 1 restarts at min_x.
        set_view(-2097152, 1048576, 1638, -1048576, 1048576, 2185);
        sbus.req = 10'h3FF;
        start_frame();
        found  = 1'b0;
        last_x = '0;
        for (int c = 0; c < 3000 && !found; c++) begin
            tick();
            if (sbus.out_valid) begin
                if (sbus.out_y != fx(-1048576)) begin
                    found = 1'b1;
                    chk("vp_row1_addr", sbus.out_addr, 1921);
                    chk("vp_row1_x", sbus.out_x, fx(-2097152));
                    chk("vp_row1_y", sbus.out_y, fx(-1048576 + 2185));
                    chk("vp_row0_last_x", last_x, fx(1047808));
                end else begin
                    last_x = sbus.out_x;
                end
            end
        end
        chk("vp_row1_seen", {31'b0, found}, 1);
        do_reset();

`ifdef SOLVER_DISPATCH_PAUSE_EN
        // Pause mid-frame holds the walk position.
        set_view(0, 1000, 1, 0, 1000, 1);
        sbus.req = 10'h3FF;
        start_frame();
        for (int c = 0; c < 10; c++) tick();
        chk("pz_pre_valid", sbus.out_valid, 1);
        first_addr = sbus.out_addr;
        pause = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("pz_valid", sbus.out_valid, 0);
            chk("pz_busy", busy, 1);
        end
        pause = 1'b0;
        tick();
        chk("pz_resume_valid", sbus.out_valid, 1);
        chk("pz_resume_addr", sbus.out_addr, first_addr + 1);
        do_reset();
`else
        first_addr = '0;
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
